// File: rtl/cpu_pkg.sv
// Shared Mini SRC definitions: opcodes, ALU select codes, sequencer states and
// instruction classes.
package cpu_pkg;

  localparam int unsigned OPW_DEF  = 5;
  localparam int unsigned ALUW_DEF = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } iclass_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and DataPath (slave).
interface control_sequencer_if #(
  parameter int unsigned ALUW = 5
);
  logic [31:0]     IR;
  logic            CON;
  logic            PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable;
  logic            MARin, PCin, MDRin, IRin, Yin;
  logic            Gra, Grb, Grc, Rin, Rout, BAout;
  logic            read, write, conin;
  logic            ZMuxEnable, ZSelect, ZMuxOut;
  logic            OutPortenable, PortInout, R15in;
  logic [ALUW-1:0] aluControl;
  logic            run;

  modport master (
    input  IR, CON,
    output PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable,
    output MARin, PCin, MDRin, IRin, Yin,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output read, write, conin,
    output ZMuxEnable, ZSelect, ZMuxOut,
    output OutPortenable, PortInout, R15in,
    output aluControl, run
  );

  modport slave (
    output IR, CON,
    input  PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable,
    input  MARin, PCin, MDRin, IRin, Yin,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  read, write, conin,
    input  ZMuxEnable, ZSelect, ZMuxOut,
    input  OutPortenable, PortInout, R15in,
    input  aluControl, run
  );
endinterface

// File: rtl/opcode_decode.sv
// Maps an opcode to its execute-sequence class and the ALU select it needs.
module opcode_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 5
) (
  input  logic [OPW-1:0]  i_opcode,
  output iclass_t         o_class,
  output logic [ALUW-1:0] o_alu
);

  always_comb begin
    o_class = CL_NOP;
    o_alu   = ALUW'(ALU_NONE);
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        o_class = CL_ALU;
        o_alu   = ALUW'(i_opcode);
      end
      OP_ADDI: begin o_class = CL_IMM; o_alu = ALUW'(ALU_ADD); end
      OP_ANDI: begin o_class = CL_IMM; o_alu = ALUW'(ALU_AND); end
      OP_ORI:  begin o_class = CL_IMM; o_alu = ALUW'(ALU_OR);  end
      OP_LDI:  begin o_class = CL_LDI; o_alu = ALUW'(ALU_ADD); end
      OP_LD:   begin o_class = CL_LD;  o_alu = ALUW'(ALU_ADD); end
      OP_ST:   begin o_class = CL_ST;  o_alu = ALUW'(ALU_ADD); end
      OP_BR:   begin o_class = CL_BR;  o_alu = ALUW'(ALU_ADD); end
      OP_JR:   o_class = CL_JR;
      OP_JAL:  o_class = CL_JAL;
      OP_IN:   o_class = CL_IN;
      OP_OUT:  o_class = CL_OUT;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for Mini SRC: fetch T0-T2, class-specific
// execute T3-T7, strobes decoded from state and IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 5
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  state_t          r_state;
  state_t          w_next;
  iclass_t         w_class;
  logic [ALUW-1:0] w_alu;
  logic            w_unused;

  assign w_unused = &{1'b0, bus.IR[31-OPW:0]};

  opcode_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
    .i_opcode (bus.IR[31:32-OPW]),
    .o_class  (w_class),
    .o_alu    (w_alu)
  );

  always_ff @(posedge clock) begin
    if (clear) r_state <= RST;
    else       r_state <= w_next;
  end

  // Each class returns to T0 after its last execute step; only halt parks.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RST:  w_next = T0;
      T0:   w_next = T1;
      T1:   w_next = T2;
      T2:   w_next = T3;
      T3: begin
        unique case (w_class)
          CL_HALT:                        w_next = HALT;
          CL_NOP, CL_JR, CL_IN, CL_OUT:   w_next = T0;
          default:                        w_next = T4;
        endcase
      end
      T4:   w_next = (w_class == CL_JAL) ? T0 : T5;
      T5: begin
        if (w_class == CL_LD || w_class == CL_ST || w_class == CL_BR) w_next = T6;
        else                                                         w_next = T0;
      end
      T6:   w_next = (w_class == CL_BR) ? T0 : T7;
      T7:   w_next = T0;
      HALT: w_next = HALT;
      default: w_next = RST;
    endcase
  end

  always_comb begin
    {bus.PCout, bus.IncPC, bus.ZLOout, bus.ZLOin, bus.Cout, bus.MDRout, bus.RAMenable} = '0;
    {bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin}                               = '0;
    {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout}                         = '0;
    {bus.read, bus.write, bus.conin}                                                  = '0;
    {bus.ZMuxEnable, bus.ZSelect, bus.ZMuxOut}                                        = '0;
    {bus.OutPortenable, bus.PortInout, bus.R15in}                                     = '0;
    bus.aluControl = '0;
    bus.run        = 1'b1;
    unique case (r_state)
      T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; end
      T1: begin bus.read = 1'b1; bus.RAMenable = 1'b1; bus.MDRin = 1'b1; end
      T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      T3: begin
        unique case (w_class)
          CL_ALU, CL_IMM:        begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST:  begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          CL_BR:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.conin = 1'b1; end
          CL_JR:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          CL_JAL: begin bus.PCout = 1'b1; bus.R15in = 1'b1; end
          CL_IN:  begin bus.PortInout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_OUT: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortenable = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        unique case (w_class)
          CL_ALU: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1; bus.aluControl = w_alu;
          end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin
            bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.aluControl = w_alu;
          end
          CL_BR:  begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
          CL_JAL: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        unique case (w_class)
          CL_ALU, CL_IMM, CL_LDI: begin
            bus.ZMuxEnable = 1'b1; bus.ZMuxOut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          CL_LD, CL_ST: begin bus.ZLOout = 1'b1; bus.MARin = 1'b1; end
          CL_BR: begin bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.aluControl = w_alu; end
          default: ;
        endcase
      end
      T6: begin
        unique case (w_class)
          CL_LD: begin bus.read = 1'b1; bus.RAMenable = 1'b1; bus.MDRin = 1'b1; end
          CL_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          CL_BR: begin bus.ZLOout = bus.CON; bus.PCin = bus.CON; end
          default: ;
        endcase
      end
      T7: begin
        unique case (w_class)
          CL_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_ST: begin bus.write = 1'b1; bus.RAMenable = 1'b1; end
          default: ;
        endcase
      end
      HALT: bus.run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: walks each instruction class T-state by T-state against
// hand-written strobe words {run, aluControl, 27 strobes}.
module tb_control_sequencer;

  logic clk;
  logic clear;

  control_sequencer_if #(.ALUW(5)) bus ();

  control_sequencer #(.OPW(5), .ALUW(5)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [32:0] obs;
  assign obs = {bus.run, bus.aluControl,
                bus.PCout, bus.IncPC, bus.ZLOout, bus.ZLOin, bus.Cout, bus.MDRout, bus.RAMenable,
                bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                bus.read, bus.write, bus.conin,
                bus.ZMuxEnable, bus.ZSelect, bus.ZMuxOut,
                bus.OutPortenable, bus.PortInout, bus.R15in};

  localparam logic [26:0] PCOUT = 27'd1 << 26, INCPC = 27'd1 << 25, ZLOOUT = 27'd1 << 24;
  localparam logic [26:0] ZLOIN = 27'd1 << 23, COUT = 27'd1 << 22, MDROUT = 27'd1 << 21;
  localparam logic [26:0] RAMEN = 27'd1 << 20, MARIN = 27'd1 << 19, PCIN = 27'd1 << 18;
  localparam logic [26:0] MDRIN = 27'd1 << 17, IRIN = 27'd1 << 16, YIN = 27'd1 << 15;
  localparam logic [26:0] GRA = 27'd1 << 14, GRB = 27'd1 << 13, GRC = 27'd1 << 12;
  localparam logic [26:0] RIN = 27'd1 << 11, ROUT = 27'd1 << 10, BAOUT = 27'd1 << 9;
  localparam logic [26:0] READ = 27'd1 << 8, WRITE = 27'd1 << 7, CONIN = 27'd1 << 6;
  localparam logic [26:0] ZMUXEN = 27'd1 << 5, ZMUXOUT = 27'd1 << 3;
  localparam logic [26:0] OUTPEN = 27'd1 << 2, PORTIO = 27'd1 << 1, R15IN = 27'd1;

  localparam logic [32:0] W_F0   = {1'b1, 5'd0, PCOUT | MARIN | INCPC};
  localparam logic [32:0] W_F1   = {1'b1, 5'd0, READ | RAMEN | MDRIN};
  localparam logic [32:0] W_F2   = {1'b1, 5'd0, MDROUT | IRIN};
  localparam logic [32:0] W_IDLE = {1'b1, 5'd0, 27'd0};
  localparam logic [32:0] W_WB   = {1'b1, 5'd0, ZMUXEN | ZMUXOUT | GRA | RIN};
  localparam logic [32:0] W_BAY  = {1'b1, 5'd0, GRB | BAOUT | YIN};
  localparam logic [32:0] W_ADDC = {1'b1, 5'b00011, COUT | ZLOIN};
  localparam logic [32:0] W_HALT = 33'd0;

  int checks = 0;
  int errors = 0;
  logic [32:0] e [0:19];
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.IR = 32'h0; bus.CON = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== W_IDLE) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h expected %h", c, obs, W_IDLE);
      end
    end
    clear = 1'b0;
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL reset_to_T0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_rtype(input logic [4:0] op, input string nm);
    bus.IR = {op, 27'h5a5a5a5};
    e[0] = W_F0; e[1] = W_F1; e[2] = W_F2;
    e[3] = {1'b1, 5'd0, GRB | ROUT | YIN};
    e[4] = {1'b1, op, GRC | ROUT | ZLOIN};
    e[5] = W_WB; e[6] = W_F0; n = 7;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL %s step%0d: got %h expected %h", nm, k, obs, e[k]);
      end
      if (k < n - 1) tick();
    end
  endtask

  task automatic test_imm(input logic [4:0] op, input logic [4:0] alu, input string nm);
    bus.IR = {op, 27'h1234567};
    e[0] = W_F0; e[1] = W_F1; e[2] = W_F2;
    e[3] = {1'b1, 5'd0, GRB | ROUT | YIN};
    e[4] = {1'b1, alu, COUT | ZLOIN};
    e[5] = W_WB; e[6] = W_F0; n = 7;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL %s step%0d: got %h expected %h", nm, k, obs, e[k]);
      end
      if (k < n - 1) tick();
    end
  endtask

  task automatic test_memory();
    // ldi, ld, st back to back
    for (int t = 0; t < 3; t++) begin
      bus.IR = (t == 0) ? {5'b00001, 27'h0000042} :
               (t == 1) ? {5'b00000, 27'h0000055} : {5'b00010, 27'h0000077};
      e[0] = W_F0; e[1] = W_F1; e[2] = W_F2; e[3] = W_BAY; e[4] = W_ADDC;
      if (t == 0) begin
        e[5] = W_WB; e[6] = W_F0; n = 7;
      end else begin
        e[5] = {1'b1, 5'd0, ZLOOUT | MARIN};
        e[6] = (t == 1) ? {1'b1, 5'd0, READ | RAMEN | MDRIN} : {1'b1, 5'd0, GRA | ROUT | MDRIN};
        e[7] = (t == 1) ? {1'b1, 5'd0, MDROUT | GRA | RIN} : {1'b1, 5'd0, WRITE | RAMEN};
        e[8] = W_F0; n = 9;
      end
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs !== e[k]) begin
          errors++;
          $display("FAIL mem%0d step%0d: got %h expected %h", t, k, obs, e[k]);
        end
        if (k < n - 1) tick();
      end
    end
  endtask

  task automatic test_branch(input logic con);
    bus.IR = {5'b10010, 27'h0800010};
    bus.CON = con;
    e[0] = W_F0; e[1] = W_F1; e[2] = W_F2;
    e[3] = {1'b1, 5'd0, GRA | ROUT | CONIN};
    e[4] = {1'b1, 5'd0, PCOUT | YIN};
    e[5] = W_ADDC;
    e[6] = con ? {1'b1, 5'd0, ZLOOUT | PCIN} : W_IDLE;
    e[7] = W_F0; n = 8;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL branch_con%0d step%0d: got %h expected %h", con, k, obs, e[k]);
      end
      if (k < n - 1) tick();
    end
    bus.CON = 1'b0;
  endtask

  task automatic test_short();
    // jr, jal, in, out, nop, unassigned opcode
    for (int t = 0; t < 6; t++) begin
      e[0] = W_F0; e[1] = W_F1; e[2] = W_F2; e[4] = W_F0; n = 5;
      unique case (t)
        0: begin bus.IR = {5'b10011, 27'h0}; e[3] = {1'b1, 5'd0, GRA | ROUT | PCIN}; end
        1: begin
          bus.IR = {5'b10100, 27'h0};
          e[3] = {1'b1, 5'd0, PCOUT | R15IN};
          e[4] = {1'b1, 5'd0, GRA | ROUT | PCIN};
          e[5] = W_F0; n = 6;
        end
        2: begin bus.IR = {5'b10101, 27'h0}; e[3] = {1'b1, 5'd0, PORTIO | GRA | RIN}; end
        3: begin bus.IR = {5'b10110, 27'h0}; e[3] = {1'b1, 5'd0, GRA | ROUT | OUTPEN}; end
        4: begin bus.IR = {5'b11010, 27'h0}; e[3] = W_IDLE; end
        default: begin bus.IR = {5'b11111, 27'h7ffffff}; e[3] = W_IDLE; end
      endcase
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs !== e[k]) begin
          errors++;
          $display("FAIL short%0d step%0d: got %h expected %h", t, k, obs, e[k]);
        end
        if (k < n - 1) tick();
      end
    end
  endtask

  task automatic test_clear_mid_ld();
    bus.IR = {5'b00000, 27'h0000099};
    e[0] = W_F0; e[1] = W_F1; e[2] = W_F2; e[3] = W_BAY; e[4] = W_ADDC;
    e[5] = {1'b1, 5'd0, ZLOOUT | MARIN};
    e[6] = W_IDLE; e[7] = W_F0; e[8] = W_F1; e[9] = W_F2; n = 10;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL clear_mid_ld step%0d: got %h expected %h", k, obs, e[k]);
      end
      if (k == 5) clear = 1'b1;
      if (k == 6) begin
        clear = 1'b0;
        bus.IR = {5'b11010, 27'h0};
      end
      if (k < n - 1) tick();
    end
    tick();
    tick();
  endtask

  task automatic test_halt();
    bus.IR = {5'b11011, 27'h0};
    e[0] = W_F0; e[1] = W_F1; e[2] = W_F2; e[3] = W_IDLE;
    for (int k = 4; k < 16; k++) e[k] = W_HALT;
    n = 16;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL halt step%0d: got %h expected %h", k, obs, e[k]);
      end
      tick();
    end
    clear = 1'b1;
    bus.IR = {5'b11010, 27'h0};
    tick();
    checks++;
    if (obs !== W_IDLE) begin
      errors++;
      $display("FAIL halt_clear: got %h expected %h", obs, W_IDLE);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL halt_restart: got %h expected %h", obs, W_F0);
    end
  endtask

  initial begin
    clear = 1'b1;
    bus.IR = '0;
    bus.CON = 1'b0;
    test_reset();
    test_imm(5'b01110, 5'b00110, "ori");
    test_imm(5'b01100, 5'b00011, "addi");
    test_imm(5'b01101, 5'b00101, "andi");
    test_rtype(5'b00100, "sub");
    test_rtype(5'b01011, "shl");
    test_rtype(5'b01010, "shra");
    test_memory();
    test_branch(1'b0);
    test_branch(1'b1);
    test_short();
    test_clear_mid_ld();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC CPU. It generates, per T-state, the control strobes that a directed bench would otherwise drive into DataPath by hand.
- It sits beside DataPath. It receives IR and the CON flag, and drives every DataPath control input.
- It sequences fetch (T0–T2) followed by an opcode-specific execute sequence (T3–T7).

Parameters:
- OPW, 5, opcode width (IR[31:27])
- ALUW, 5, aluControl width

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- IR  in  32  current instruction from DataPath
- CON  in  1  branch-condition flag from the con_ff in DataPath
- PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable  out  1 each  DataPath strobes
- MARin, PCin, MDRin, IRin, Yin  out  1 each  register load enables
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select and encode controls
- read, write, conin  out  1 each  memory and condition controls
- ZMuxEnable, ZSelect, ZMuxOut  out  1 each  Z write-back mux controls
- OutPortenable, PortInout, R15in  out  1 each  I/O and link controls
- aluControl  out  5  ALU operation select
- run  out  1  high unless halted

Behaviour:
- Clock and reset: one clock, `clock`. Reset `clear` is synchronous and active-high.
- Timing: the state register updates on posedge clock. Outputs are decoded combinationally from the state and IR. DataPath captures at the following posedge, so each state lasts exactly 1 cycle.
- Reset: on `clear`, go to RST. In RST all strobes are 0, aluControl is 0 and run is 1. The next state is T0.
- Clear mid-instruction aborts the instruction immediately. No partial write-back occurs after the clear edge.
- Default for any strobe not listed in a state: 0. aluControl holds 0 outside ALU states.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
  - T2 always goes to T3. Decode uses IR[31:27] as loaded at the end of T2.
- R-type ALU (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLOin, aluControl=opcode.
  - T5: ZMuxEnable, ZMuxOut, ZSelect=0, Gra, Rin. Then T0.
- Immediate (addi, andi, ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLOin. aluControl maps addi→00011, andi→00101, ori→00110.
  - T5: same as R-type T5.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ZLOin, aluControl=00011.
  - T5: Z write-back to Ra.
- ld:
  - T3–T4: same as ldi.
  - T5: ZLOout, MARin.
  - T6: read, RAMenable, MDRin.
  - T7: MDRout, Gra, Rin.
- st:
  - T3–T4: same as ldi.
  - T5: ZLOout, MARin.
  - T6: Gra, Rout, MDRin (read=0).
  - T7: write, RAMenable.
- branch:
  - T3: Gra, Rout, conin.
  - T4: PCout, Yin.
  - T5: Cout, ZLOin, aluControl=00011.
  - T6: if CON=1 then ZLOout, PCin; if CON=0, no strobes. CON is sampled in T6.
- jr — T3: Gra, Rout, PCin.
- jal:
  - T3: PCout, R15in.
  - T4: Gra, Rout, PCin.
- in — T3: PortInout, Gra, Rin.
- out — T3: Gra, Rout, OutPortenable.
- nop and unassigned opcodes: T3 with no strobes, then T0.
- halt: T3 → HALT. In HALT all strobes are 0 and run=0. HALT is held until `clear`.
- Counter-based execute: the last execute step of each class returns to T0. No state skips fetch.

Decomposition:
- Shared package `cpu_pkg` holds:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, br 10010, jr 10011, jal 10100, in 10101, out 10110, nop 11010, halt 11011;
  - the state enum RST, T0–T7, HALT;
  - the aluControl codes.
- One natural sub-module: `opcode_decode`. It takes IR[31:27] and returns the instruction class and the mapped aluControl.

Test Plan:
- Reset: `clear` for 2 cycles → all strobes 0 and run=1. On the first cycle after release, T0 asserts PCout=MARin=IncPC=1.
- ori (IR=0x7?…, opcode 01110): T3 asserts Grb, Rout, Yin. T4 asserts Cout, ZLOin, aluControl=00110. T5 asserts ZMuxEnable, ZMuxOut, Gra, Rin. Cycle 6 returns to T0.
- ld (opcode 00000): 8-cycle instruction. T6 asserts read, RAMenable, MDRin. T7 asserts MDRout, Gra, Rin.
- branch with CON=0, then CON=1: T6 has no PCin for CON=0, and asserts ZLOout+PCin for CON=1.
- clear asserted during ld T5 → next cycle is RST with all strobes 0. T6/T7 strobes never appear.
- halt (opcode 11011) → run=0 from T4 onward, with all strobes 0 for 10+ cycles. A subsequent clear restores run=1 and restarts T0.
